// File: rtl/serial_frame_rx.sv
// serial_frame_rx: two-wire serial link receiver.
// Synchronises the serial clock and data into clk, hunts for the sync byte,
// deserialises FRAME_LEN payload bytes per frame and re-checks sync at every
// frame boundary. Loss of lock is flagged on a bad sync byte or a stalled link.
module serial_frame_rx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_LEN = 4,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       sdata_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       sync_err,
  output logic       timeout_err
);

  localparam int             IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0]  IDLE_PRE = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  IDLE_ONE = IW'(1);
  localparam logic [7:0]     LEN8     = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  // Synchroniser and edge-detect flops
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdata_s1_q, sdata_s2_q;
  // Registered bit event and the data bit that goes with it
  logic bit_ev_q, bit_dat_q;

  state_t          state_q, state_d;
  logic [7:0]      win_q, win_d, win_new;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d, byte_inc;
  logic [IW-1:0]   idle_q, idle_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            locked_q, locked_d;
  logic            sync_err_q, sync_err_d;
  logic            timeout_err_q, timeout_err_d;

  // Bring both link wires into clk and register the rising-edge event of sclk
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      sdata_s1_q <= 1'b0;
      sdata_s2_q <= 1'b0;
      bit_ev_q   <= 1'b0;
      bit_dat_q  <= 1'b0;
    end else begin
      sclk_s1_q  <= sclk_in;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdata_s1_q <= sdata_in;
      sdata_s2_q <= sdata_s1_q;
      bit_ev_q   <= sclk_s2_q & ~sclk_s3_q;
      bit_dat_q  <= sdata_s2_q;
    end
  end

  // Framing state, counters, idle timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      win_q         <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 8'd0;
      idle_q        <= '0;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_q        <= idle_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic: a bit event always wins over the idle timeout
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    sync_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    win_new       = {win_q[6:0], bit_dat_q};
    byte_inc      = byte_cnt_q + 8'd1;

    // Idle timer saturates so a long stall raises only one pulse
    if (bit_ev_q) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = idle_q;
    end

    if (bit_ev_q) begin
      win_d = win_new;
      case (state_q)
        ST_HUNT: begin
          if (win_new == SYNC_BYTE) begin
            state_d    = ST_PAYLOAD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_out_d   = win_new;
            data_valid_d = 1'b1;
            byte_cnt_d   = byte_inc;
            if (byte_inc == LEN8) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = 8'd0;
            if (win_new == SYNC_BYTE) begin
              state_d = ST_PAYLOAD;
            end else begin
              // Window is kept so the hunt can match on the very next bit
              state_d    = ST_HUNT;
              sync_err_d = 1'b1;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
        default: begin
          state_d    = ST_HUNT;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
        end
      endcase
    end else if ((idle_q == IDLE_PRE) && (state_q != ST_HUNT)) begin
      // Stalled link while framed: drop lock and discard any partial byte
      state_d       = ST_HUNT;
      bit_cnt_d     = 3'd0;
      byte_cnt_d    = 8'd0;
      timeout_err_d = 1'b1;
    end else begin
      state_d = state_q;
    end

    locked_d = (state_d != ST_HUNT);
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed bit streams, a stream-level frame model
// and a per-cycle compare process, plus literal byte/pulse expectations.
module tb_serial_frame_rx;

  localparam int         TO   = 64;
  localparam int         FL   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, sclk_in, sdata_in;
  logic [7:0] data_out;
  logic       data_valid, locked, sync_err, timeout_err;

  serial_frame_rx #(.SYNC_BYTE(SYNC), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdata_in(sdata_in),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .sync_err(sync_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         kind;   // 0 none, 1 payload byte, 2 bad check byte
    logic [7:0] byt;
    bit         lk;
  } ev_t;

  ev_t evq[$];
  int  checks = 0, errors = 0;
  bit  started = 1'b0;
  int  rst_due = -1;

  // Stream under test and the model's per-bit outcome
  bit         bq[0:1023];
  int         nb;
  int         ek[0:1023];
  logic [7:0] eb[0:1023];
  bit         el[0:1023];

  // Observations from the DUT
  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  int n_serr, n_terr, terr_cyc, last_rise;

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Value of the 8 most recent bits ending at index e (bits before the stream are 0)
  function automatic logic [7:0] win_at(input int e);
    logic [7:0] r;
    r = 8'h00;
    for (int t = e - 7; t <= e; t++) r = {r[6:0], (t >= 0) ? bq[t] : 1'b0};
    return r;
  endfunction

  // Frame-level scan of the whole stream: find sync, take FL bytes, check sync
  function automatic void analyze();
    int j, s, e;
    bit done;
    for (int i = 0; i < nb; i++) begin ek[i] = 0; eb[i] = 8'h00; el[i] = 1'b0; end
    j = 0;
    while (j < nb) begin
      if (win_at(j) != SYNC) begin
        j++;
      end else begin
        s = j;
        done = 1'b0;
        while (!done) begin
          for (int i = s; i < s + 8 * (FL + 1) && i < nb; i++) el[i] = 1'b1;
          for (int b = 1; b <= FL; b++) begin
            e = s + 8 * b;
            if (e < nb) begin ek[e] = 1; eb[e] = win_at(e); end
          end
          e = s + 8 * (FL + 1);
          if (e >= nb) begin
            done = 1'b1; j = nb;
          end else if (win_at(e) == SYNC) begin
            s = e;
          end else begin
            ek[e] = 2; el[e] = 1'b0; done = 1'b1; j = e + 1;
          end
        end
      end
    end
  endfunction

  task automatic add_byte(input logic [7:0] v);
    for (int t = 7; t >= 0; t--) begin bq[nb] = v[t]; nb++; end
  endtask

  task automatic add_bit(input bit b);
    bq[nb] = b; nb++;
  endtask

  // Transmit the stream: lo cycles low (data set up), then hi cycles high
  task automatic send_stream(input int hi, input int lo);
    analyze();
    for (int k = 0; k < nb; k++) begin
      ev_t ev;
      sclk_in  = 1'b0;
      sdata_in = bq[k];
      repeat (lo) @(negedge clk);
      sclk_in   = 1'b1;
      last_rise = cyc + 1;
      ev.due = cyc + 4;
      ev.kind = ek[k];
      ev.byt = eb[k];
      ev.lk = el[k];
      evq.push_back(ev);
      repeat (hi) @(negedge clk);
    end
    sclk_in = 1'b0;
  endtask

  task automatic do_reset();
    sclk_in = 1'b0;
    rst     = 1'b1;
    rst_due = cyc + 1;
    evq.delete();
    started = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_obs();
    got.delete();
    n_serr = 0; n_terr = 0; terr_cyc = -1; nb = 0;
  endtask

  task automatic check_bytes(input string nm);
    check1({nm, "_count"}, got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      check1({nm, "_byte"}, got[i], exp_b[i]);
  endtask

  // Per-cycle compare of all outputs against the model
  bit         m_lock = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         last_ev = -1;
  always @(negedge clk) begin : chk
    ev_t e;
    bit  e_dv, e_se, e_te;
    if (started) begin
      if (cyc == rst_due) begin
        m_lock = 1'b0; m_data = 8'h00; last_ev = -1;
        check1("rst_data_out", data_out, 8'h00);
        check1("rst_data_valid", data_valid, 1'b0);
        check1("rst_locked", locked, 1'b0);
        check1("rst_sync_err", sync_err, 1'b0);
        check1("rst_timeout_err", timeout_err, 1'b0);
      end else begin
        e_dv = 1'b0; e_se = 1'b0; e_te = 1'b0;
        if (evq.size() > 0 && evq[0].due == cyc) begin
          e = evq.pop_front();
          last_ev = cyc;
          if (e.kind == 1) begin e_dv = 1'b1; m_data = e.byt; end
          if (e.kind == 2) e_se = 1'b1;
          m_lock = e.lk;
        end else if (last_ev >= 0 && cyc == last_ev + TO && m_lock) begin
          e_te = 1'b1;
          m_lock = 1'b0;
        end
        check1("data_valid", data_valid, e_dv);
        check1("data_out", data_out, m_data);
        check1("locked", locked, m_lock);
        check1("sync_err", sync_err, e_se);
        check1("timeout_err", timeout_err, e_te);
      end
      if (data_valid) got.push_back(data_out);
      if (sync_err) n_serr++;
      if (timeout_err) begin n_terr++; terr_cyc = cyc; end
    end
  end

  initial begin
    rst = 1'b1; sclk_in = 1'b0; sdata_in = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset mid-frame, then a normal frame
    clear_obs();
    add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22);
    send_stream(8, 8);
    repeat (4) @(negedge clk);
    do_reset();
    nb = 0;
    add_byte(8'hA5); add_byte(8'h33); add_byte(8'h44); add_byte(8'h55); add_byte(8'h66);
    send_stream(8, 8);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_bytes("rst_frame");
    check1("rst_frame_serr", n_serr, 0);
    repeat (100) @(negedge clk);

    // Clean two-frame stream at clk/16
    do_reset();
    clear_obs();
    add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
    add_byte(8'hA5); add_byte(8'h55); add_byte(8'h66); add_byte(8'h77); add_byte(8'h88);
    send_stream(8, 8);
    repeat (6) @(negedge clk);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_bytes("clean");
    check1("clean_serr", n_serr, 0);
    check1("clean_terr", n_terr, 0);
    repeat (100) @(negedge clk);

    // Leading junk before sync
    do_reset();
    clear_obs();
    add_bit(1'b1); add_bit(1'b0); add_bit(1'b1); add_bit(1'b0);
    add_byte(8'hA5); add_byte(8'hDE); add_byte(8'hAD); add_byte(8'hBE); add_byte(8'hEF);
    send_stream(8, 8);
    repeat (6) @(negedge clk);
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check_bytes("junk");
    check1("junk_serr", n_serr, 0);
    repeat (100) @(negedge clk);

    // Bad check byte, then relock
    do_reset();
    clear_obs();
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03); add_byte(8'h04);
    add_byte(8'h5A);
    add_byte(8'hA5); add_byte(8'h09); add_byte(8'h0A); add_byte(8'h0B); add_byte(8'h0C);
    send_stream(8, 8);
    repeat (6) @(negedge clk);
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    check_bytes("badchk");
    check1("badchk_serr", n_serr, 1);
    repeat (100) @(negedge clk);

    // Stall mid-byte
    do_reset();
    clear_obs();
    add_byte(8'hA5); add_byte(8'h01);
    add_bit(1'b1); add_bit(1'b0); add_bit(1'b1);
    send_stream(8, 8);
    repeat (150) @(negedge clk);
    exp_b = '{8'h01};
    check_bytes("stall");
    check1("stall_terr_count", n_terr, 1);
    check1("stall_terr_delay", terr_cyc - last_rise, TO + 3);
    check1("stall_locked", locked, 1'b0);

    // Minimum serial clock period (3 high / 3 low)
    do_reset();
    clear_obs();
    add_byte(8'hA5); add_byte(8'hC3); add_byte(8'h3C); add_byte(8'h81); add_byte(8'h7E);
    add_byte(8'hA5); add_byte(8'hFF); add_byte(8'h00); add_byte(8'h96); add_byte(8'h69);
    send_stream(3, 3);
    repeat (6) @(negedge clk);
    exp_b = '{8'hC3, 8'h3C, 8'h81, 8'h7E, 8'hFF, 8'h00, 8'h96, 8'h69};
    check_bytes("minclk");
    check1("minclk_serr", n_serr, 0);
    repeat (100) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive side of the board's two-wire serial link: the link carries a divided serial clock and a data line shifted MSB-first on its rising edge. This block synchronises both wires into the system clock domain, hunts for a sync byte, deserialises the fixed-length payload that follows, and re-verifies sync at every frame boundary. Bytes are delivered as single-cycle valid pulses to downstream logic. Loss of lock is flagged on a bad sync byte or a stalled serial clock.

## Interface
- SYNC_BYTE, 8'hA5: frame delimiter, compared MSB-first.
- FRAME_LEN, 4: payload bytes per frame (1..255).
- TIMEOUT, 64: clk cycles without a serial-clock rising edge before lock is dropped (≥8).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sclk_in  in  1  serial clock from the transmitter, asynchronous to clk.
- sdata_in  in  1  serial data, valid around sclk_in rising edge.
- data_out  out  8  last received payload byte.
- data_valid  out  1  one-cycle pulse; data_out holds a new payload byte.
- locked  out  1  high while framed (PAYLOAD or CHECK).
- sync_err  out  1  one-cycle pulse when the check byte is not SYNC_BYTE.
- timeout_err  out  1  one-cycle pulse when lock is dropped by TIMEOUT.

## Operation
- sclk_in and sdata_in each pass through two flops (s1, s2); a third flop on sclk (s3) forms the edge detector. Bit event = s2 & ~s3. On a bit event, sdata s2 is shifted into an 8-bit window LSB-side: win <= {win[6:0], sdata_s2}.
- States: HUNT, PAYLOAD, CHECK. A 3-bit bit counter and an 8-bit byte counter are used.
- HUNT: on every bit event, if the new window value equals SYNC_BYTE, go to PAYLOAD with bit_cnt=0, byte_cnt=0. The match is checked on the post-shift value.
- PAYLOAD: bit_cnt increments per bit event. On the 8th bit, the new window value goes to data_out and data_valid pulses. byte_cnt increments. When byte_cnt reaches FRAME_LEN, go to CHECK with bit_cnt=0.
- CHECK: collect 8 bits. If the new window equals SYNC_BYTE, go to PAYLOAD and clear the counters; locked stays high and no gap is allowed. Otherwise, sync_err pulses and the state goes to HUNT. The window is not cleared, so a match is possible on the very next bit.
- Idle counter: cleared on each bit event, otherwise increments and saturates at TIMEOUT. When it transitions to TIMEOUT in PAYLOAD or CHECK:
  - go to HUNT;
  - clear bit_cnt and byte_cnt;
  - pulse timeout_err.
  In HUNT, reaching TIMEOUT produces no pulse. Saturation prevents a repeat pulse during a single idle period.
- Simultaneity: a bit event and a timeout cannot coincide, because the bit event clears the counter and takes priority. A partial byte in progress at timeout is discarded.
- Arithmetic: byte_cnt compared against FRAME_LEN (8-bit); bit_cnt wraps 7→0.

## Timing
- Reset (rst high at a clk edge) sets:
  - state HUNT; win, counters, sync and edge flops to 0;
  - data_out=8'h00; data_valid, locked, sync_err, timeout_err = 0.
  Reset mid-frame discards everything. After rst releases, the first sclk rise is detectable 3 cycles later.
- Latency: a sclk_in rise sampled at edge N produces the bit event at N+2. Registered outputs (data_valid, data_out, locked, sync_err) are visible at N+3.
- locked rises the cycle after the sync-match bit event and falls the cycle after the sync_err or timeout_err decision, coincident with the pulse.
- sclk_in high and low phases must each last ≥3 clk cycles, so the serial clock period is ≥6 clk; a clk/16 transmitter is in range. sdata_in must be stable 3 clk cycles before and 1 after each sclk rise.
- data_valid pulses are at least 8 bit periods apart.

## Test plan
- Reset mid-frame: assert rst for 1 cycle after 2 payload bytes → all outputs 0 next cycle, state HUNT; the following sync plus payload is received normally.
- Clean frame: serial clock at clk/16, send A5 11 22 33 44 A5 55 66 77 88 → locked high after the first A5; data_valid pulses 8 times with 11,22,33,44,55,66,77,88; no errors.
- Hunt with leading junk: send bits 1010 then A5 DE AD BE EF → locked only after the A5 completes; bytes DE AD BE EF out. The preceding pattern must not produce a false lock unless the window actually equals A5.
- Bad check byte: A5 01 02 03 04 5A → 4 bytes out, then sync_err pulse for 1 cycle and locked low. A following A5 09 … relocks with 09 as the first byte.
- Stall: A5 01, then hold sclk_in low 64+ cycles → timeout_err one pulse exactly TIMEOUT cycles after the last bit event, locked low. No second pulse while the stall continues; no data_valid for the partial byte.
- Minimum clock: serial clock period 6 clk (3 high/3 low) with a full frame → all bytes correct.
